// File: rtl/drfuzz_stim_harness.sv
// Fuzz stimulus harness: buffers frames, sequences DUT reset/run/drain and keeps a sticky coverage map.
// Optional DRFUZZ_COVER_COUNT_EN adds a registered population count of the coverage map.
module drfuzz_stim_harness #(
    parameter int FuzzInWidth = 176,
    parameter int CoverWidth  = 634,
    parameter int FifoDepth   = 16,
    parameter int ResetCycles = 4,
    parameter int DrainCycles = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   meta_rst_ni,
    input  logic                   frame_valid_i,
    input  logic [FuzzInWidth-1:0] frame_data_i,
    output logic                   frame_ready_o,
    input  logic                   start_i,
    output logic                   dut_rst_no,
    output logic [FuzzInWidth-1:0] fuzz_o,
    input  logic [CoverWidth-1:0]  cover_i,
    output logic [CoverWidth-1:0]  cover_map_o,
    output logic                   new_cover_o,
`ifdef DRFUZZ_COVER_COUNT_EN
    output logic [$clog2(CoverWidth+1)-1:0] cover_count_o,
`endif
    output logic                   done_o
);

    localparam int AW         = $clog2(FifoDepth);
    localparam int TW         = 16;
    localparam int DRAIN_LOAD = (DrainCycles > 0) ? DrainCycles - 1 : 0;

    // state    | meaning
    // S_IDLE   | waiting for start_i after reset
    // S_DUTRST | DUT held in reset for ResetCycles cycles
    // S_RUN    | one buffered frame popped to fuzz_o per cycle
    // S_DRAIN  | coverage settles for DrainCycles cycles
    // S_DONE   | run finished, waiting for next start_i
    typedef enum logic [2:0] {S_IDLE, S_DUTRST, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic [CoverWidth-1:0]   map_q, map_d;
    logic                    seen_new_q, seen_new_d;
    logic                    new_cover_q, new_cover_d;
    logic                    live_q, live_d;
    logic [FuzzInWidth-1:0]  fifo_mem [FifoDepth];

    logic   empty, full, push, pop, empty_d, in_or, new_bits;
    state_t exit_state;

    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = (state_q == S_RUN) && !empty;
        // A pop in the same cycle frees a slot, so a full buffer may still accept
        frame_ready_o = live_q && (!full || pop);
        push       = frame_valid_i && frame_ready_o;
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
        empty_d    = (wr_ptr_d == rd_ptr_d);
        exit_state = (DrainCycles > 0) ? S_DRAIN : S_DONE;
        live_d     = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            map_q       <= '0;
            seen_new_q  <= 1'b0;
            new_cover_q <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            map_q       <= map_d;
            seen_new_q  <= seen_new_d;
            new_cover_q <= new_cover_d;
            live_q      <= live_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= frame_data_i;
        end
    end

    // RUN is skipped entirely when nothing will be buffered at its first cycle
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_DUTRST;
                    timer_d = TW'(ResetCycles - 1);
                end
            end
            S_DUTRST: begin
                if (timer_q == '0) begin
                    if (!empty_d) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = exit_state;
                        timer_d = TW'(DRAIN_LOAD);
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_RUN: begin
                if (empty_d) begin
                    state_d = exit_state;
                    timer_d = TW'(DRAIN_LOAD);
                end
            end
            S_DRAIN: begin
                if (timer_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_or    = (state_q == S_RUN) || (state_q == S_DRAIN);
        map_d    = map_q;
        if (in_or) begin
            map_d = map_q | cover_i;
        end
        if (!meta_rst_ni) begin
            map_d = '0;
        end
        new_bits   = in_or && meta_rst_ni && (|(cover_i & ~map_q));
        seen_new_d = seen_new_q | new_bits;
        if ((state_q == S_IDLE || state_q == S_DONE) && start_i) begin
            seen_new_d = 1'b0;
        end
        new_cover_d = (state_d == S_DONE) && (state_q != S_DONE) && seen_new_d;
    end

    always_comb begin
        fuzz_o      = pop ? fifo_mem[rd_ptr_q[AW-1:0]] : '0;
        dut_rst_no  = live_q && (state_q != S_DUTRST);
        done_o      = (state_q == S_DONE);
        new_cover_o = new_cover_q;
        cover_map_o = map_q;
    end

`ifdef DRFUZZ_COVER_COUNT_EN
    localparam int CNT_W = $clog2(CoverWidth+1);
    logic [CNT_W-1:0] cover_count_q, cover_count_d;

    always_comb begin
        cover_count_d = '0;
        for (int i = 0; i < CoverWidth; i++) begin
            cover_count_d = cover_count_d + {{(CNT_W-1){1'b0}}, map_q[i]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cover_count_q <= '0;
        end else begin
            cover_count_q <= cover_count_d;
        end
    end

    assign cover_count_o = cover_count_q;
`endif

endmodule

// File: tb/tb_drfuzz_stim_harness.sv
// Self-checking bench for drfuzz_stim_harness: vector table, hand sequences and randomized runs vs. a queue model.
module tb_drfuzz_stim_harness;
    localparam int FW = 176;
    localparam int CW = 634;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic          meta_rst_ni = 1'b1;
    logic          frame_valid_i = 1'b0;
    logic [FW-1:0] frame_data_i = '0;
    logic          frame_ready_o;
    logic          start_i = 1'b0;
    logic          dut_rst_no;
    logic [FW-1:0] fuzz_o;
    logic [CW-1:0] cover_i = '0;
    logic [CW-1:0] cover_map_o;
    logic          new_cover_o;
    logic          done_o;
`ifdef DRFUZZ_COVER_COUNT_EN
    logic [$clog2(CW+1)-1:0] cover_count_o;
`endif

    drfuzz_stim_harness dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .meta_rst_ni   (meta_rst_ni),
        .frame_valid_i (frame_valid_i),
        .frame_data_i  (frame_data_i),
        .frame_ready_o (frame_ready_o),
        .start_i       (start_i),
        .dut_rst_no    (dut_rst_no),
        .fuzz_o        (fuzz_o),
        .cover_i       (cover_i),
        .cover_map_o   (cover_map_o),
        .new_cover_o   (new_cover_o),
`ifdef DRFUZZ_COVER_COUNT_EN
        .cover_count_o (cover_count_o),
`endif
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: buffered frames in order, and the sticky coverage map
    logic [FW-1:0] mq[$];
    logic [CW-1:0] mmap = '0;

    typedef struct {
        int            nfr;
        logic [CW-1:0] cov;
        int            exp_done;
        logic          exp_new;
    } vec_t;
    vec_t vt[5];

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] onehot(input int b);
        logic [CW-1:0] v;
        v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[FW-1:0] | {{(FW-1){1'b0}}, 1'b1};
    endfunction

    task automatic push_frame(input logic [FW-1:0] d);
        frame_valid_i = 1'b1;
        frame_data_i  = d;
        @(negedge clk_i);
        chk("ready", frame_ready_o, mq.size() < 16);
        if (mq.size() < 16) mq.push_back(d);
        @(posedge clk_i);
        #1 frame_valid_i = 1'b0;
    endtask

    // Cycle k counts from the first DUTRST cycle; frames expected at k=4.., done at 6+frames.
    task automatic run_check(input int push_k, input logic [FW-1:0] pdata, input logic [CW-1:0] cov,
                             input int exp_done, input logic exp_new);
        logic [FW-1:0] expq[$];
        int   rstcnt = 0;
        int   done_k = -1;
        int   npulse = 0;
        int   idx = 0;
        logic new_at_done = 1'b0;
        logic acc = 1'b0;
        expq = mq;
        if (push_k >= 0) expq.push_back(pdata);
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        cover_i = cov;
        for (int k = 0; k < 80; k++) begin
            frame_valid_i = (k == push_k);
            frame_data_i  = pdata;
            @(negedge clk_i);
            if (k == push_k) acc = frame_ready_o;
            if (!dut_rst_no) rstcnt++;
            if (fuzz_o != '0) begin
                if (idx < expq.size()) chk("frame", fuzz_o, expq[idx]);
                else chk("extra_frame", fuzz_o, 0);
                chk("frame_cycle", k, 4 + idx);
                idx++;
            end
            if (new_cover_o) npulse++;
            if (done_o) begin
                done_k = k;
                new_at_done = new_cover_o;
                break;
            end
            @(posedge clk_i);
            #1;
        end
        frame_valid_i = 1'b0;
        cover_i = '0;
        chk("dut_rst_len", rstcnt, 4);
        chk("frame_count", idx, expq.size());
        chk("done_cycle", done_k, exp_done);
        chk("new_at_done", new_at_done, exp_new);
        chk("new_pulses", npulse, exp_new);
        if (push_k >= 0) chk("push_in_run", acc, 1);
        mmap |= cov;
        chk("cover_map", cover_map_o, mmap);
        mq.delete();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [CW-1:0] cov;
        logic [FW-1:0] pd;
        int n;

        vt[0] = '{3, onehot(5), 9, 1'b1};
        vt[1] = '{3, onehot(5), 9, 1'b0};
        vt[2] = '{0, onehot(7), 6, 1'b1};
        vt[3] = '{1, onehot(5) | onehot(7), 7, 1'b0};
        vt[4] = '{2, onehot(633), 8, 1'b1};

        #1 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_dut_rst_no", dut_rst_no, 0);
        chk("rst_ready", frame_ready_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_fuzz", fuzz_o, 0);
        chk("rst_map", cover_map_o, 0);
        chk("rst_new", new_cover_o, 0);
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rel_dut_rst_no", dut_rst_no, 1);
        chk("rel_ready", frame_ready_o, 1);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vt[v].nfr; i++) push_frame(rand_frame());
            run_check(-1, '0, vt[v].cov, vt[v].exp_done, vt[v].exp_new);
        end

        // No accumulation outside RUN/DRAIN, then meta clear wins
        cover_i = onehot(9);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("idle_no_or", cover_map_o, mmap);
        @(posedge clk_i);
        #1 cover_i = onehot(5);
        meta_rst_ni = 1'b0;
        @(posedge clk_i);
        #1 meta_rst_ni = 1'b1;
        @(negedge clk_i);
        chk("meta_clear", cover_map_o, 0);
        mmap = '0;
        cover_i = '0;
        @(posedge clk_i);
        #1;

        // Full buffer: 17th refused, 16 replayed in order
        for (int i = 0; i < 17; i++) push_frame(rand_frame());
        chk("full_model", mq.size(), 16);
        run_check(-1, '0, '0, 22, 1'b0);

        // Push while full and popping in the first RUN cycle
        for (int i = 0; i < 16; i++) push_frame(rand_frame());
        run_check(4, rand_frame(), '0, 23, 1'b0);

        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(0, 18);
            for (int i = 0; i < n; i++) push_frame(rand_frame());
            cov = onehot($urandom_range(0, CW-1));
            if ($urandom_range(0, 1) == 1) cov |= onehot($urandom_range(0, CW-1));
            run_check(-1, '0, cov, 6 + mq.size(), |(cov & ~mmap));
        end

        // Reset in the middle of RUN with five frames still buffered
        for (int i = 0; i < 8; i++) push_frame(rand_frame());
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        cover_i = onehot(11);
        repeat (7) @(posedge clk_i);
        #1;
        pd = mq[3];
        chk("midrun_fuzz", fuzz_o, pd);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_dut_rst_no", dut_rst_no, 0);
        chk("mid_rst_ready", frame_ready_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_fuzz", fuzz_o, 0);
        chk("mid_rst_map", cover_map_o, 0);
        chk("mid_rst_new", new_cover_o, 0);
        mq.delete();
        mmap = '0;
        cover_i = '0;
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("mid_rel_dut_rst_no", dut_rst_no, 1);
        chk("mid_rel_ready", frame_ready_o, 1);
        run_check(-1, '0, onehot(0) | onehot(3) | onehot(633), 6, 1'b1);
`ifdef DRFUZZ_COVER_COUNT_EN
        chk("cover_count", cover_count_o, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
